// File: rtl/icdir_ctl_pkg.sv
// icdir_ctl_pkg: shared constants, entry layout and state encoding for the I-cache directory controller
package icdir_ctl_pkg;
  localparam int IC_LINES = 128;
  localparam int IC_IDX_W = $clog2(IC_LINES);
  localparam int IC_OFF_W = 6;
  localparam int IC_TAG_W = 32 - IC_IDX_W - IC_OFF_W;
  localparam int IC_DIR_W = 22;
  localparam int IC_DIR_V = 21;
  localparam int IC_TAG_HI = 18;
  localparam logic [IC_IDX_W-1:0] IC_LAST = IC_IDX_W'(IC_LINES - 1);
  typedef enum logic [2:0] {S_INV, S_IDLE, S_REQ, S_WAIT, S_FILL} state_t;
endpackage

// File: rtl/icdir_ctl_if.sv
// icdir_ctl_if: fetch, reload, invalidate and directory-port signals of the I-cache directory controller
interface icdir_ctl_if;
  import icdir_ctl_pkg::*;
  logic f_val;
  logic [31:0] f_adr;
  logic f_rdy;
  logic f_hit;
  logic f_miss;
  logic f_err;
  logic rld_req;
  logic [31:0] rld_adr;
  logic rld_gnt;
  logic rld_done;
  logic rld_err;
  logic inv_req;
  logic inv_busy;
  logic [IC_IDX_W-1:0] dir_rd_adr;
  logic [IC_DIR_W-1:0] dir_rd_dat;
  logic [3:0] dir_wr_en;
  logic [IC_IDX_W-1:0] dir_wr_adr;
  logic [IC_DIR_W-1:0] dir_wr_dat;
  modport slave (
    input f_val, f_adr, rld_gnt, rld_done, rld_err, inv_req, dir_rd_dat,
    output f_rdy, f_hit, f_miss, f_err, rld_req, rld_adr, inv_busy,
    output dir_rd_adr, dir_wr_en, dir_wr_adr, dir_wr_dat
  );
  modport master (
    output f_val, f_adr, rld_gnt, rld_done, rld_err, inv_req, dir_rd_dat,
    input f_rdy, f_hit, f_miss, f_err, rld_req, rld_adr, inv_busy,
    input dir_rd_adr, dir_wr_en, dir_wr_adr, dir_wr_dat
  );
endinterface

// File: rtl/icdir_ctl.sv
// icdir_ctl: I-cache directory lookup, miss reload and invalidate-sweep controller
module icdir_ctl
  import icdir_ctl_pkg::*;
(
  input logic clk,
  input logic rst,
  icdir_ctl_if.slave bus
);
  state_t state;
  logic [IC_IDX_W-1:0] ctr, idx;
  logic [IC_TAG_W-1:0] tag;
  logic hit_q, miss_q, err_q, hit, wr, unused;
  assign hit = bus.dir_rd_dat[IC_DIR_V] && bus.dir_rd_dat[IC_TAG_HI:0] == bus.f_adr[31 -: IC_TAG_W];
  // rst gates the write strobe so the directory sees no writes while reset is held
  assign wr = !rst && (state == S_INV || state == S_FILL);
  assign unused = ^{bus.dir_rd_dat[IC_DIR_V-1:IC_TAG_HI+1], bus.f_adr[IC_OFF_W-1:0]};
  assign bus.f_rdy = state == S_IDLE && !bus.inv_req;
  assign bus.f_hit = hit_q;
  assign bus.f_miss = miss_q;
  assign bus.f_err = err_q;
  assign bus.rld_req = state == S_REQ;
  assign bus.rld_adr = {tag, idx, {IC_OFF_W{1'b0}}};
  assign bus.inv_busy = state == S_INV;
  assign bus.dir_rd_adr = state == S_IDLE ? bus.f_adr[IC_OFF_W +: IC_IDX_W] : idx;
  assign bus.dir_wr_en = {4{wr}};
  assign bus.dir_wr_adr = state == S_INV ? ctr : idx;
  assign bus.dir_wr_dat = state == S_INV ? '0 : {1'b1, 2'b00, tag};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_INV;
      ctr <= '0;
      idx <= '0;
      tag <= '0;
      hit_q <= 1'b0;
      miss_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      hit_q <= 1'b0;
      miss_q <= 1'b0;
      err_q <= 1'b0;
      case (state)
        S_INV: begin
          ctr <= ctr + 1'b1;
          state <= ctr == IC_LAST ? S_IDLE : S_INV;
        end
        S_IDLE:
          if (bus.inv_req) begin
            ctr <= '0;
            state <= S_INV;
          end else if (bus.f_val) begin
            hit_q <= hit;
            miss_q <= !hit;
            if (!hit) begin
              idx <= bus.f_adr[IC_OFF_W +: IC_IDX_W];
              tag <= bus.f_adr[31 -: IC_TAG_W];
              state <= S_REQ;
            end
          end
        S_REQ: state <= bus.rld_gnt ? S_WAIT : S_REQ;
        S_WAIT:
          if (bus.rld_done) begin
            err_q <= bus.rld_err;
            state <= bus.rld_err ? S_IDLE : S_FILL;
          end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_icdir_ctl.sv
// tb_icdir_ctl: self-checking bench for icdir_ctl; models the directory as a valid bit and tag per index
module tb_icdir_ctl;
  import icdir_ctl_pkg::*;
  typedef struct {logic [6:0] a; logic [21:0] d; logic [3:0] en;} wr_t;
  typedef struct {logic [31:0] a; bit err; bit hit;} vec_t;
  logic clk = 0, rst = 0, scramble = 1;
  int errors = 0, checks = 0;
  logic [21:0] dir [128];
  wr_t wlog [$];
  bit mv [128];
  logic [18:0] mt [128];
  logic [6:0] ixs [4] = '{7'h03, 7'h5A, 7'h7F, 7'h00};
  logic [18:0] tgs [4] = '{19'h0, 19'h1, 19'h7FFFF, 19'h091A2};
  icdir_ctl_if bus();
  icdir_ctl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.dir_rd_dat = dir[bus.dir_rd_adr];
  always @(posedge clk)
    if (scramble) for (int i = 0; i < 128; i++) dir[i] <= 22'($urandom);
    else if (bus.dir_wr_en != 4'h0) begin
      dir[bus.dir_wr_adr] <= bus.dir_wr_dat;
      wlog.push_back('{bus.dir_wr_adr, bus.dir_wr_dat, bus.dir_wr_en});
    end

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic bit mhit(input logic [31:0] a);
    return mv[a[12:6]] && mt[a[12:6]] == a[31:13];
  endfunction

  function automatic bit is_fill(input int k, input logic [31:0] a);
    return k < wlog.size() && wlog[k].a == a[12:6] && wlog[k].d == {1'b1, 2'b00, a[31:13]} && wlog[k].en == 4'hF;
  endfunction

  task automatic wait_rdy(output bit ok);
    for (int i = 0; i < 400 && !bus.f_rdy; i++) @(negedge clk);
    ok = bus.f_rdy;
  endtask

  task automatic check_sweep(input int first);
    int bad = 0;
    for (int i = 0; i < IC_LINES; i++)
      if (first + i >= wlog.size() || wlog[first+i].a != 7'(i) || wlog[first+i].d != 22'h0 || wlog[first+i].en != 4'hF) bad++;
    chk("sweep_entries", 64'(bad), 64'(0));
    chk("sweep_len", 64'(wlog.size()), 64'(first + IC_LINES));
    for (int i = 0; i < 128; i++) mv[i] = 0;
  endtask

  task automatic do_reset();
    bit ok;
    @(negedge clk);
    rst = 1;
    bus.f_val = 0; bus.rld_gnt = 0; bus.rld_done = 0; bus.rld_err = 0; bus.inv_req = 0;
    #1;
    chk("rst_rld_req", 64'(bus.rld_req), 64'(0));
    chk("rst_f_rdy", 64'(bus.f_rdy), 64'(0));
    chk("rst_inv_busy", 64'(bus.inv_busy), 64'(1));
    chk("rst_pulses", 64'({bus.f_hit, bus.f_miss, bus.f_err}), 64'(0));
    repeat (3) @(negedge clk);
    chk("rst_wr_en", 64'(bus.dir_wr_en), 64'(0));
    scramble = 0;
    wlog.delete();
    rst = 0;
    wait_rdy(ok);
    chk("sweep_done", 64'(ok), 64'(1));
    check_sweep(0);
  endtask

  task automatic lookup(input logic [31:0] a, output logic h, output logic m);
    bit ok;
    wait_rdy(ok);
    chk("lookup_rdy", 64'(ok), 64'(1));
    bus.f_val = 1; bus.f_adr = a;
    #1 chk("rd_adr", 64'(bus.dir_rd_adr), 64'(a[12:6]));
    @(negedge clk);
    bus.f_val = 0; bus.f_adr = $urandom;
    h = bus.f_hit; m = bus.f_miss;
  endtask

  task automatic serve(input logic [31:0] a, input bit err, input bit inv_wait);
    logic [31:0] al;
    int dg, dd;
    al = {a[31:6], 6'b0};
    dg = $urandom_range(0, 3);
    dd = $urandom_range(0, 3);
    chk("rld_req", 64'({bus.rld_req, bus.rld_adr}), 64'({1'b1, al}));
    for (int i = 0; i < dg; i++) begin
      bus.rld_done = 1'($urandom); bus.rld_err = 1'($urandom);
      @(negedge clk);
      bus.rld_done = 0; bus.rld_err = 0;
      chk("rld_hold", 64'({bus.rld_req, bus.rld_adr}), 64'({1'b1, al}));
    end
    bus.rld_gnt = 1;
    @(negedge clk);
    bus.rld_gnt = 0;
    chk("rld_req_drop", 64'({bus.rld_req, bus.f_rdy}), 64'(0));
    if (inv_wait) bus.inv_req = 1;
    repeat (dd) @(negedge clk);
    bus.rld_done = 1; bus.rld_err = err;
    @(negedge clk);
    bus.rld_done = 0; bus.rld_err = 0;
    chk("f_err", 64'(bus.f_err), 64'(err));
  endtask

  task automatic step(input logic [31:0] a, input bit err, input bit exp_h, input bit inv_wait);
    logic h, m;
    bit ok;
    wlog.delete();
    lookup(a, h, m);
    chk("hit_miss", 64'({h, m}), exp_h ? 64'(2'b10) : 64'(2'b01));
    if (h && !m) begin
      chk("hit_idle", 64'(bus.f_rdy), 64'(1));
      chk("hit_no_wr", 64'(wlog.size()), 64'(0));
    end else if (m) begin
      serve(a, err, inv_wait);
      if (inv_wait) begin
        for (int i = 0; i < 8 && !bus.inv_busy; i++) @(negedge clk);
        chk("inv_taken", 64'(bus.inv_busy), 64'(1));
        bus.inv_req = 0;
        wait_rdy(ok);
        chk("inv_done", 64'(ok), 64'(1));
        chk("fill_before_inv", 64'(is_fill(0, a)), 64'(1));
        check_sweep(1);
      end else begin
        wait_rdy(ok);
        chk("fill_rdy", 64'(ok), 64'(1));
        chk("fill_wr_cnt", 64'(wlog.size()), err ? 64'(0) : 64'(1));
        if (!err) begin
          chk("fill_dat", 64'(is_fill(0, a)), 64'(1));
          mv[a[12:6]] = 1;
          mt[a[12:6]] = a[31:13];
        end
      end
    end
  endtask

  task automatic inv_step();
    bit ok;
    wait_rdy(ok);
    wlog.delete();
    bus.inv_req = 1; bus.f_val = 1; bus.f_adr = $urandom;
    @(negedge clk);
    bus.f_val = 0;
    chk("inv_prio", 64'({bus.f_hit, bus.f_miss, bus.inv_busy}), 64'(3'b001));
    bus.inv_req = 0;
    wait_rdy(ok);
    chk("inv_rdy", 64'(ok), 64'(1));
    check_sweep(0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [11];
    logic h, m;
    logic [31:0] a;
    bus.f_val = 0; bus.f_adr = 0; bus.rld_gnt = 0; bus.rld_done = 0; bus.rld_err = 0; bus.inv_req = 0;
    tbl = '{
      '{32'h0000_1040, 0, 0},
      '{32'h0000_107F, 0, 1},
      '{32'h1234_5680, 0, 0},
      '{32'h1234_5680, 0, 1},
      '{32'h5678_1680, 0, 0},
      '{32'h1234_5680, 0, 0},
      '{32'h1234_56BC, 0, 1},
      '{32'h0000_2000, 1, 0},
      '{32'h0000_2000, 0, 0},
      '{32'h0000_2000, 0, 1},
      '{32'h0000_1040, 0, 1}
    };
    do_reset();
    foreach (tbl[i]) step(tbl[i].a, tbl[i].err, tbl[i].hit, 0);
    // invalidate raised while waiting for reload data: fill lands first, then the sweep
    step(32'h0000_3000, 0, 0, 1);
    step(32'h0000_1040, 0, 0, 0);
    // reset while a reload request is outstanding
    lookup(32'h0000_5000, h, m);
    chk("t6_miss", 64'({h, m}), 64'(2'b01));
    chk("t6_req", 64'(bus.rld_req), 64'(1));
    do_reset();
    step(32'h1234_5680, 0, 0, 0);
    step(32'h1234_5680, 0, 1, 0);
    for (int n = 0; n < 80; n++)
      if ($urandom_range(0, 19) == 0) inv_step();
      else begin
        a = {tgs[$urandom_range(0, 3)], ixs[$urandom_range(0, 3)], 6'($urandom)};
        step(a, $urandom_range(0, 3) == 0, mhit(a), 0);
      end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
